// File: rtl/mont_reduce.sv
// Word-serial Montgomery reducer: r = t * 2^-DATA_WIDTH mod MODULUS, one WORD digit per iteration.
// Define MONT_REDUCE_LAZY_EN to drop the final subtract (r in [0,2p), one cycle less latency).
module mont_reduce #(
  parameter int unsigned           DATA_WIDTH = 256,
  parameter int unsigned           WORD       = 64,
  parameter int unsigned           NWORDS     = 4,
  parameter logic [DATA_WIDTH-1:0] MODULUS    =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter logic [WORD-1:0]       NPRIME     = 64'h87d20782e4866389
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] t,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   r,
  output logic                    busy
);

  localparam int unsigned AccW  = 2 * DATA_WIDTH + WORD + 1;
  localparam int unsigned ProdW = DATA_WIDTH + WORD;
  localparam int unsigned CntW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(NWORDS - 1);

  typedef enum logic [2:0] {StIdle, StMulM, StAcc, StFinal, StHold} state_e;

  state_e                state_q, state_d;
  logic [AccW-1:0]       acc_q, acc_d, acc_next;
  logic [AccW:0]         acc_sum;
  logic [ProdW-1:0]      mp;
  logic [WORD-1:0]       m_q, m_d;
  logic [CntW-1:0]       i_q, i_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
  logic                  last_iter;
  logic                  acc_step;

  // Full-width m*p added into A; low WORD bits of the sum are zero by choice of m.
  assign mp        = {{DATA_WIDTH{1'b0}}, m_q} * {{WORD{1'b0}}, MODULUS};
  assign acc_sum   = {1'b0, acc_q} + {{(AccW + 1 - ProdW){1'b0}}, mp};
  assign acc_next  = AccW'(acc_sum >> WORD);
  assign last_iter = (i_q == LastIter);
  assign acc_step  = (state_q == StAcc);

`ifndef MONT_REDUCE_LAZY_EN
  logic                  acc_ge;
  logic [DATA_WIDTH-1:0] acc_sub;
  assign acc_ge  = acc_q >= {{(AccW - DATA_WIDTH){1'b0}}, MODULUS};
  // Result is below p whenever the subtract is taken, so truncating is exact.
  assign acc_sub = acc_q[DATA_WIDTH-1:0] - MODULUS;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StMulM;
      StMulM:  state_d = StAcc;
`ifdef MONT_REDUCE_LAZY_EN
      StAcc:   state_d = last_iter ? StHold : StMulM;
`else
      StAcc:   state_d = last_iter ? StFinal : StMulM;
`endif
      StFinal: state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StHold);
    busy      = (state_q != StIdle);
    r         = r_q;
  end

  always_comb begin
    acc_d = acc_q;
    m_d   = m_q;
    i_d   = i_q;
    r_d   = r_q;
    if (state_q == StIdle && in_valid) begin
      acc_d = {{(AccW - 2 * DATA_WIDTH){1'b0}}, t};
      i_d   = '0;
    end
    if (state_q == StMulM) begin
      m_d = acc_q[WORD-1:0] * NPRIME;
    end
    if (acc_step) begin
      acc_d = acc_next;
      if (!last_iter) begin
        i_d = i_q + 1'b1;
      end
`ifdef MONT_REDUCE_LAZY_EN
      else begin
        r_d = acc_next[DATA_WIDTH-1:0];
      end
`endif
    end
`ifndef MONT_REDUCE_LAZY_EN
    if (state_q == StFinal) begin
      r_d = acc_ge ? acc_sub : acc_q[DATA_WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      m_q   <= '0;
      i_q   <= '0;
      r_q   <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
      i_q   <= i_d;
      r_q   <= r_d;
    end
  end

endmodule

// File: tb/tb_mont_reduce.sv
// Scoreboard bench for mont_reduce; honours MONT_REDUCE_LAZY_EN when defined.
module tb_mont_reduce;

  localparam logic [255:0] P =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
`ifdef MONT_REDUCE_LAZY_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 10;
`endif
  localparam int PERIOD = LAT + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [511:0] t = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [255:0] r;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           last_acc = 0;
  int           hs_cyc = 0;
  logic         ov_prev = 1'b0;
  logic [255:0] exp_q[$];
  int           lat_q[$];
  logic [255:0] e;

  mont_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .t         (t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: reduce mod p, then halve mod p 256 times.
  function automatic logic [255:0] golden(input logic [511:0] tt);
    logic [256:0] x;
    x = 257'(tt % {256'b0, P});
    for (int k = 0; k < 256; k++) x = x[0] ? ((x + {1'b0, P}) >> 1) : (x >> 1);
    return x[255:0];
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v % P;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (dut.acc_step) check("acc_low_zero", 512'(dut.acc_sum[63:0]), '0);
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) check("latency_pending", 512'(0), 512'(1));
        else check("latency", 512'(cyc + 1 - lat_q.pop_front()), 512'(LAT));
      end
      if (out_valid && out_ready) begin
        hs_cyc <= cyc + 1;
        if (exp_q.size() == 0) begin
          check("spurious_output", 512'(1), 512'(0));
        end else begin
          e = exp_q.pop_front();
`ifdef MONT_REDUCE_LAZY_EN
          check("lazy_range", 512'({1'b0, r} < {P, 1'b0}), 512'(1));
          check("result_mod_p", 512'(r % P), 512'(e));
`else
          check("result", 512'(r), 512'(e));
`endif
        end
      end
    end
    ov_prev <= out_valid;
  end

  // Call at posedge+1; returns at posedge+1 after the accept edge, in_valid left high.
  task automatic send(input logic [511:0] tv, input logic [255:0] ev);
    int n;
    in_valid = 1'b1;
    t = tv;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 512'(0), 512'(1));
    end else begin
      exp_q.push_back(ev);
      lat_q.push_back(cyc + 1);
      last_acc = cyc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain", 512'(exp_q.size()), 512'(0));
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] dir_t[4];
    logic [255:0] dir_e[4];
    logic [511:0] tv;
    logic [255:0] a, b, r0;
    int           prev, n;

    dir_t[0] = 512'd1 << 256;       dir_e[0] = 256'd1;
    dir_t[1] = '0;                   dir_e[1] = '0;
    dir_t[2] = {P - 256'd1, 256'b0}; dir_e[2] = P - 256'd1;
    dir_t[3] = {256'd5, 256'b0};     dir_e[3] = 256'd5;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 512'(in_ready), 512'(1));
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_r", 512'(r), '0);
    check("rst_busy", 512'(busy), 512'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    for (int k = 0; k < 4; k++) begin
      send(dir_t[k], dir_e[k]);
      in_valid = 1'b0;
      wait_drain();
    end

    // Backpressure: hold result, offer a second item while held.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(dir_t[0], dir_e[0]);
    check("busy_after_accept", 512'(busy), 512'(1));
    t = dir_t[3];
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_out_valid_seen", 512'(out_valid), 512'(1));
    r0 = r;
    repeat (6) begin
      @(negedge clk);
      check("hold_out_valid", 512'(out_valid), 512'(1));
      check("hold_r_stable", 512'(r), 512'(r0));
      check("hold_in_ready", 512'(in_ready), 512'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(dir_t[3], dir_e[3]);
    check("accept_after_hs", 512'(last_acc), 512'(hs_cyc + 1));
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back random products with in_valid held high.
    prev = 0;
    for (int k = 0; k < 1000; k++) begin
      a = rand_fe();
      b = rand_fe();
      tv = {256'b0, a} * {256'b0, b};
      prev = last_acc;
      send(tv, golden(tv));
      if (k > 0) check("accept_spacing", 512'(last_acc - prev), 512'(PERIOD));
    end
    in_valid = 1'b0;
    wait_drain();
    check("r_nonzero_before_reset", 512'(r != '0), 512'(1));

    // Reset five cycles into a reduction.
    send(dir_t[2], dir_e[2]);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_out_valid", 512'(out_valid), 512'(0));
    check("abort_r", 512'(r), '0);
    check("abort_in_ready", 512'(in_ready), 512'(1));
    check("abort_busy", 512'(busy), 512'(0));
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(dir_t[0], dir_e[0]);
    in_valid = 1'b0;
    wait_drain();
    repeat (15) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mont_reduce.md
Name: mont_reduce

Overview:
- Word-serial Montgomery reducer; sits directly downstream of the 256x256 Karatsuba multiplier.
- Consumes its 512-bit product T and returns r = T * 2^-256 mod p for the Groth16 base field.
- Radix 2^64, four iterations, one shared 64x256 multiplier, valid/ready handshake on both sides.
- The upstream sequencer supplies in_valid, delayed to match the multiplier's 3-cycle latency.

Parameters:
- DATA_WIDTH, 256, operand/result width; must equal NWORDS*WORD.
- WORD, 64, reduction digit width.
- NWORDS, 4, iterations per reduction.
- MODULUS, 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47, field prime p (BN254 Fq).
- NPRIME, 64'h87d20782e4866389, -p^-1 mod 2^64.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  T is valid.
- in_ready  out  1  block can accept T.
- t  in  512  product from the multiplier (z_q); precondition T < p*2^256.
- out_valid  out  1  r is valid.
- out_ready  in  1  downstream accepts r.
- r  out  256  reduced result.
- busy  out  1  high in any state except IDLE.

Behaviour:
Reset (rst=0, async):
- State IDLE; in_ready=1, out_valid=0, r=0, busy=0.
- Accumulator, digit m and iteration counter cleared.
- Reset mid-operation discards the in-flight item; no partial output is ever presented.

Datapath:
- 577-bit accumulator A; 64-bit digit register m; 2-bit counter i.
- The 64x256 product m*p is computed combinationally and summed into A without truncation.

FSM:
- IDLE: in_ready=1. On in_valid&in_ready: A<=t, i<=0, go MUL_M.
- MUL_M: m <= (A[63:0]*NPRIME) mod 2^64. Go ACC.
- ACC: A <= (A + m*MODULUS) >> 64.
  - The low 64 bits of the sum must be zero; the verification bench asserts this.
  - If i==3, go FINAL; else i<=i+1, go MUL_M.
- FINAL: r <= (A>=MODULUS) ? A-MODULUS : A[255:0]; out_valid<=1; go HOLD.
  - The A>=MODULUS compare uses the full accumulator width.
- HOLD: r and out_valid stable until out_ready.
  - On out_valid&out_ready: out_valid<=0, go IDLE.
  - out_ready ignored in all other states.

Timing:
- Latency: accept edge = cycle 0; out_valid high from cycle 10.
- Throughput: one reduction per 11 cycles with out_ready tied high.
- in_ready is high only in IDLE; no skid buffer. Upstream holds t while in_valid&!in_ready.
- Output handshake completing on cycle k: in_ready=1 at k+1, so the next accept is no earlier than k+1.
- in_valid while busy has no effect.

Arithmetic/bounds:
- Given T < p*2^256, A < 2p after iteration 3, so one conditional subtract suffices; r is in [0,p).
- T=0 gives r=0.
- Violating the precondition is undefined; no flag without the optional feature.

Optional Feature:
- Macro: MONT_REDUCE_LAZY_EN.
- Defined:
  - FINAL state removed; after the last ACC, r<=A[255:0] and out_valid<=1 directly.
  - Latency 9 cycles; r is in [0,2p), for chained lazy-reduction datapaths.
  - Requires 2p < 2^256, true for the default modulus.
- Undefined: full reduction as above, latency 10, r in [0,p).

Test Plan:
- Basic reduction: t=2^256 -> r=1, out_valid rises exactly 10 cycles after accept. Also t=0 -> r=0.
- Boundary subtract path: t=(p-1)<<256 -> r=p-1, and t=5<<256 -> r=5. Cross-check 1000 random T=a*b (a,b<p) against a golden model computing a*b*2^-256 mod p.
- Backpressure:
  - Hold out_ready=0 for 6 cycles after out_valid: r and out_valid stay stable, in_ready=0.
  - A second in_valid offered meanwhile is accepted only the cycle after the out handshake.
- Back-to-back with out_ready=1 and in_valid continuously high: accepts every 11 cycles; results are in order and match the golden model.
- Reset mid-operation:
  - Drop rst at cycle 5 after accept: out_valid=0, r=0, in_ready=1 immediately (asynchronous).
  - After release, a new t=2^256 yields r=1 with no trace of the aborted item.
- MONT_REDUCE_LAZY_EN:
  - t=(p-1)<<256 gives r=p-1 at latency 9.
  - Random T gives r in [0,2p) with r mod p equal to the golden model.
